// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default widths,
// control-bundle field layout, update-mode encoding and a channel extractor.
package pipe_pkg;

    localparam int unsigned DEF_CTRL_W = 8;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_CNT_W  = 16;

    // Control bundle layout as packed by the instantiating stage: {EX, MEM, WB}
    localparam int unsigned CTRL_WB_LSB  = 0;
    localparam int unsigned CTRL_WB_W    = 2;
    localparam int unsigned CTRL_MEM_LSB = 2;
    localparam int unsigned CTRL_MEM_W   = 3;
    localparam int unsigned CTRL_EX_LSB  = 5;
    localparam int unsigned CTRL_EX_W    = 3;

    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_SQUASH = 2'd2
    } upd_e;

    function automatic logic [DEF_DATA_W-1:0] get_ch(
        input logic [DEF_NUM_CH*DEF_DATA_W-1:0] flat,
        input int unsigned                      k
    );
        return flat[k*DEF_DATA_W +: DEF_DATA_W];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that overrides increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with stall hold, flush squash,
// stall-deferred flush and saturating stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = DEF_CTRL_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     valid_i,
    input  logic [CTRL_W-1:0]        ctrl_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic                     clr_cnt_i,
    output logic                     valid_o,
    output logic [CTRL_W-1:0]        ctrl_o,
    output logic [NUM_CH*DATA_W-1:0] data_o,
    output logic                     flush_pend_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
);

    upd_e                     mode;
    logic                     valid_q, valid_d;
    logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d;
    logic                     flush_pend_q, flush_pend_d;
    logic                     bubble_inc;

    always_comb begin
        if (stall_i) begin
            mode = UPD_HOLD;
        end else if (flush_i || flush_pend_q) begin
            mode = UPD_SQUASH;
        end else begin
            mode = UPD_LOAD;
        end
    end

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        flush_pend_d = flush_pend_q;
        bubble_inc   = 1'b0;
        // Data has one shared load enable; squashed entries still load it.
        data_d       = stall_i ? data_q : data_i;
        unique case (mode)
            UPD_HOLD: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
            end
            UPD_SQUASH: begin
                valid_d      = 1'b0;
                ctrl_d       = '0;
                flush_pend_d = 1'b0;
                bubble_inc   = 1'b1;
            end
            default: begin
                valid_d    = valid_i;
                ctrl_d     = ctrl_i & {CTRL_W{valid_i}};
                bubble_inc = !valid_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            data_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_i),
        .clr_i   (clr_cnt_i),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (bubble_inc),
        .clr_i   (clr_cnt_i),
        .cnt_o   (bubble_cnt_o)
    );

    assign valid_o      = valid_q;
    assign ctrl_o       = ctrl_q;
    assign data_o       = data_q;
    assign flush_pend_o = flush_pend_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic [7:0]   ctrl_i;
    logic [127:0] data_i;
    logic         stall_i;
    logic         flush_i;
    logic         clr_cnt_i;

    logic         valid_o;
    logic [7:0]   ctrl_o;
    logic [127:0] data_o;
    logic         flush_pend_o;
    logic [15:0]  stall_cnt_o;
    logic [15:0]  bubble_cnt_o;

    logic         s_valid_o;
    logic [7:0]   s_ctrl_o;
    logic [127:0] s_data_o;
    logic         s_flush_pend_o;
    logic [1:0]   s_stall_cnt_o;
    logic [1:0]   s_bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [127:0] held_data;
    logic [127:0] exp_data;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid_i),
        .ctrl_i       (ctrl_i),
        .data_i       (data_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .clr_cnt_i    (clr_cnt_i),
        .valid_o      (valid_o),
        .ctrl_o       (ctrl_o),
        .data_o       (data_o),
        .flush_pend_o (flush_pend_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_small (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .valid_i      (valid_i),
        .ctrl_i       (ctrl_i),
        .data_i       (data_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .clr_cnt_i    (clr_cnt_i),
        .valid_o      (s_valid_o),
        .ctrl_o       (s_ctrl_o),
        .data_o       (s_data_o),
        .flush_pend_o (s_flush_pend_o),
        .stall_cnt_o  (s_stall_cnt_o),
        .bubble_cnt_o (s_bubble_cnt_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 128'(valid_o), 128'(0));
        chk({tag, " ctrl"}, 128'(ctrl_o), 128'(0));
        chk({tag, " data"}, data_o, 128'(0));
        chk({tag, " pend"}, 128'(flush_pend_o), 128'(0));
        chk({tag, " stall_cnt"}, 128'(stall_cnt_o), 128'(0));
        chk({tag, " bubble_cnt"}, 128'(bubble_cnt_o), 128'(0));
    endtask

    initial begin
        // Reset asserted from time zero with random inputs
        rst_n     = 1'b0;
        valid_i   = 1'b1;
        ctrl_i    = 8'($urandom);
        data_i    = {$urandom, $urandom, $urandom, $urandom};
        stall_i   = 1'b0;
        flush_i   = 1'b1;
        clr_cnt_i = 1'b0;
        #3;
        chk_zero("rst_t0");
        step();
        step();
        chk_zero("rst_edges");

        // Release and load first entry
        rst_n   = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b1;
        ctrl_i  = 8'hA5;
        data_i  = 128'h1234;
        step();
        chk("load valid", 128'(valid_o), 128'(1));
        chk("load ctrl", 128'(ctrl_o), 128'hA5);
        chk("load ch0", 128'(get_ch(data_o, 0)), 128'h1234);
        chk("load bubble", 128'(bubble_cnt_o), 128'(0));

        // Channel mapping
        ctrl_i = 8'h3C;
        data_i = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ch%0d", k), 128'(get_ch(data_o, k)), 128'(k + 1));
        end
        chk("ch ctrl", 128'(ctrl_o), 128'h3C);
        held_data = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};

        // Stall hold for 3 cycles while inputs change
        stall_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            valid_i = 1'b0;
            ctrl_i  = 8'hFF;
            data_i  = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("hold valid", 128'(valid_o), 128'(1));
            chk("hold ctrl", 128'(ctrl_o), 128'h3C);
            chk("hold data", data_o, held_data);
            chk("hold stall_cnt", 128'(stall_cnt_o), 128'(i));
        end
        chk("hold bubble", 128'(bubble_cnt_o), 128'(0));

        // Deferred flush: flush during stall, then two more stalled cycles
        flush_i = 1'b1;
        step();
        chk("defer pend1", 128'(flush_pend_o), 128'(1));
        chk("defer valid1", 128'(valid_o), 128'(1));
        chk("defer stall_cnt", 128'(stall_cnt_o), 128'(4));
        flush_i = 1'b0;
        step();
        step();
        chk("defer pend3", 128'(flush_pend_o), 128'(1));
        chk("defer ctrl3", 128'(ctrl_o), 128'h3C);
        chk("defer bubble3", 128'(bubble_cnt_o), 128'(0));
        stall_i  = 1'b0;
        valid_i  = 1'b1;
        ctrl_i   = 8'h77;
        data_i   = 128'hDEAD_BEEF_0000_0000_CAFE_F00D;
        exp_data = 128'hDEAD_BEEF_0000_0000_CAFE_F00D;
        step();
        chk("squash valid", 128'(valid_o), 128'(0));
        chk("squash ctrl", 128'(ctrl_o), 128'(0));
        chk("squash pend", 128'(flush_pend_o), 128'(0));
        chk("squash bubble", 128'(bubble_cnt_o), 128'(1));
        chk("squash data", data_o, exp_data);
        chk("squash stall_cnt", 128'(stall_cnt_o), 128'(6));
        step();
        chk("post squash valid", 128'(valid_o), 128'(1));
        chk("post squash ctrl", 128'(ctrl_o), 128'h77);
        chk("post squash bubble", 128'(bubble_cnt_o), 128'(1));

        // Flush without stall: single squashed entry only
        flush_i = 1'b1;
        step();
        chk("flush valid", 128'(valid_o), 128'(0));
        chk("flush ctrl", 128'(ctrl_o), 128'(0));
        chk("flush pend", 128'(flush_pend_o), 128'(0));
        chk("flush bubble", 128'(bubble_cnt_o), 128'(2));
        flush_i = 1'b0;
        step();
        chk("after flush valid", 128'(valid_o), 128'(1));
        chk("after flush ctrl", 128'(ctrl_o), 128'h77);

        // Invalid input gating
        valid_i = 1'b0;
        ctrl_i  = 8'hFF;
        step();
        chk("gate valid", 128'(valid_o), 128'(0));
        chk("gate ctrl", 128'(ctrl_o), 128'(0));
        chk("gate bubble", 128'(bubble_cnt_o), 128'(3));

        // Counter clear does not disturb pipeline state
        valid_i   = 1'b1;
        ctrl_i    = 8'h11;
        clr_cnt_i = 1'b1;
        step();
        chk("clr stall_cnt", 128'(stall_cnt_o), 128'(0));
        chk("clr bubble_cnt", 128'(bubble_cnt_o), 128'(0));
        chk("clr small stall", 128'(s_stall_cnt_o), 128'(0));
        chk("clr valid", 128'(valid_o), 128'(1));
        chk("clr ctrl", 128'(ctrl_o), 128'h11);

        // Saturation on the CNT_W=2 instance
        clr_cnt_i = 1'b0;
        stall_i   = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("sat small stall", 128'(s_stall_cnt_o), 128'((i > 3) ? 3 : i));
            chk("sat main stall", 128'(stall_cnt_o), 128'(i));
        end
        clr_cnt_i = 1'b1;
        step();
        chk("clr+stall small", 128'(s_stall_cnt_o), 128'(0));
        chk("clr+stall main", 128'(stall_cnt_o), 128'(0));
        chk("clr+stall ctrl", 128'(ctrl_o), 128'h11);
        clr_cnt_i = 1'b0;

        // Asynchronous reset pulse mid-stall with a pending flush
        flush_i = 1'b1;
        step();
        chk("pre-rst pend", 128'(flush_pend_o), 128'(1));
        chk("pre-rst stall_cnt", 128'(stall_cnt_o), 128'(1));
        flush_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        step();
        rst_n   = 1'b1;
        stall_i = 1'b0;
        valid_i = 1'b1;
        ctrl_i  = 8'hA5;
        data_i  = 128'h1234;
        step();
        chk("post-rst valid", 128'(valid_o), 128'(1));
        chk("post-rst ctrl", 128'(ctrl_o), 128'hA5);
        chk("post-rst ch0", 128'(get_ch(data_o, 0)), 128'h1234);
        chk("post-rst pend", 128'(flush_pend_o), 128'(0));
        chk("post-rst bubble", 128'(bubble_cnt_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
